// File: rtl/ls_unit.sv
// ls_unit: load/store sequencer in front of the data memory.
//
// Takes one load or store request from the execute stage, forms the effective
// address (base + offset, wrapping), and drives the memory ports. A 16-bit pair
// access is split into two byte accesses: the low byte at ea, then the high byte
// at ea+1. Load data is gathered into rdata, and done pulses for one cycle.
//
// Ports:
//   CLK, reset          clock; synchronous active-high reset
//   start               request strobe, sampled only while idle
//   is_store, is_pair   request kind (store/load, pair/byte)
//   base, offset        address operands, latched on acceptance
//   wdata               store data (low byte used for byte stores)
//   busy, done          sequencer status; done is a one-cycle completion pulse
//   rdata               load result register
//   mem_addr            memory address (registered; holds between accesses)
//   mem_read, mem_write memory strobes
//   mem_wdata           memory write data
//   mem_rdata           memory read data (combinational read of mem_addr)
module ls_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic                is_store,
  input  logic                is_pair,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W-1:0]   offset,
  input  logic [2*DATA_W-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StDone} lsState;

  lsState state, stateNext;

  logic                storeReg;
  logic                pairReg;
  logic [2*DATA_W-1:0] wdataReg;
  logic [ADDR_W-1:0]   eaReg;
  logic [2*DATA_W-1:0] rdataReg;
  logic [ADDR_W-1:0]   memAddrReg;
  logic [ADDR_W-1:0]   eaSum;

  // Carry out of the add is dropped, so the address wraps.
  assign eaSum = base + offset;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    unique case (state)
      StIdle: begin
        if (start) stateNext = StAcc0;
      end
      StAcc0: begin
        busy = 1'b1;
        if (storeReg) begin
          mem_write = 1'b1;
          mem_wdata = wdataReg[DATA_W-1:0];
        end else begin
          mem_read = 1'b1;
        end
        stateNext = pairReg ? StAcc1 : StDone;
      end
      StAcc1: begin
        busy = 1'b1;
        if (storeReg) begin
          mem_write = 1'b1;
          mem_wdata = wdataReg[2*DATA_W-1:DATA_W];
        end else begin
          mem_read = 1'b1;
        end
        stateNext = StDone;
      end
      StDone: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
    // Reset aborts at once: suppress the strobes in the cycle reset is seen so
    // an interrupted pair store leaves its high byte unwritten.
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      storeReg   <= 1'b0;
      pairReg    <= 1'b0;
      wdataReg   <= '0;
      eaReg      <= '0;
      rdataReg   <= '0;
      memAddrReg <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            storeReg   <= is_store;
            pairReg    <= is_pair;
            wdataReg   <= wdata;
            eaReg      <= eaSum;
            memAddrReg <= eaSum;
          end
        end
        StAcc0: begin
          if (!storeReg) begin
            rdataReg[DATA_W-1:0] <= mem_rdata;
            // Byte loads zero-extend; pair loads fill the top half next cycle.
            if (!pairReg) rdataReg[2*DATA_W-1:DATA_W] <= '0;
          end
          if (pairReg) memAddrReg <= eaReg + ADDR_W'(1);
        end
        StAcc1: begin
          if (!storeReg) rdataReg[2*DATA_W-1:DATA_W] <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign rdata    = rdataReg;
  assign mem_addr = memAddrReg;

endmodule

// File: tb/tb_ls_unit.sv
module tb_ls_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic        is_pair;
  logic [7:0]  base;
  logic [7:0]  offset;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  ls_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .is_pair   (is_pair),
    .base      (base),
    .offset    (offset),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Data memory model: initial contents are i ^ 0x5A.
  logic [7:0] mem [256];
  logic       memInit = 1'b0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      memInit <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } accT;

  accT         accQ[$];
  logic [15:0] doneQ[$];
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic void expW(input logic [7:0] a, input logic [7:0] d);
    accQ.push_back('{wr: 1'b1, addr: a, data: d});
  endfunction

  function automatic void expR(input logic [7:0] a);
    accQ.push_back('{wr: 1'b0, addr: a, data: 8'h00});
  endfunction

  // Monitor: compares every memory access and every done pulse with the queues.
  initial begin
    accT e;
    logic [15:0] r;
    forever begin
      @(negedge CLK);
      if (mem_read || mem_write) begin
        chk("strobe exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        if (accQ.size() == 0) begin
          chk("unexpected access", {23'd0, mem_write, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = accQ.pop_front();
          chk("access kind", {31'd0, mem_write}, {31'd0, e.wr});
          chk("access addr", {24'd0, mem_addr}, {24'd0, e.addr});
          if (e.wr) chk("access wdata", {24'd0, mem_wdata}, {24'd0, e.data});
        end
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          chk("unexpected done", {16'd0, rdata}, 32'hFFFF_FFFF);
        end else begin
          r = doneQ.pop_front();
          chk("rdata at done", {16'd0, rdata}, {16'd0, r});
        end
      end
    end
  end

  task automatic runReq(input logic st, input logic pr, input logic [7:0] b,
                        input logic [7:0] o, input logic [15:0] wd, input int expLat,
                        input string name);
    int k;
    @(negedge CLK);
    start = 1'b1; is_store = st; is_pair = pr; base = b; offset = o; wdata = wd;
    @(negedge CLK);
    start = 1'b0; base = 8'h00; offset = 8'h00; wdata = 16'h0000;
    k = 1;
    while (!done && k < 8) begin
      @(negedge CLK);
      k++;
    end
    chk({name, " latency"}, k, expLat);
    @(negedge CLK);
    chk({name, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int doneCnt;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; is_pair = 1'b0;
    base = 8'h00; offset = 8'h00; wdata = 16'h0000;
    repeat (2) @(negedge CLK);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset rdata", {16'd0, rdata}, 32'd0);
    chk("reset mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("reset strobes", {29'd0, mem_read, mem_write, |mem_wdata}, 32'd0);
    reset = 1'b0;

    // Byte store then byte load.
    expW(8'h14, 8'hA5); doneQ.push_back(16'h0000);
    runReq(1'b1, 1'b0, 8'h10, 8'h04, 16'h00A5, 2, "byte store");
    expR(8'h14); doneQ.push_back(16'h00A5);
    runReq(1'b0, 1'b0, 8'h10, 8'h04, 16'h0000, 2, "byte load");

    // Pair store/load, little-endian.
    expW(8'h20, 8'hEF); expW(8'h21, 8'hBE); doneQ.push_back(16'h00A5);
    runReq(1'b1, 1'b1, 8'h20, 8'h00, 16'hBEEF, 3, "pair store");
    chk("mem 0x20", {24'd0, mem[8'h20]}, 32'hEF);
    chk("mem 0x21", {24'd0, mem[8'h21]}, 32'hBE);
    expR(8'h20); expR(8'h21); doneQ.push_back(16'hBEEF);
    runReq(1'b0, 1'b1, 8'h20, 8'h00, 16'h0000, 3, "pair load");

    // Address wrap.
    expW(8'hFF, 8'h34); expW(8'h00, 8'h12); doneQ.push_back(16'hBEEF);
    runReq(1'b1, 1'b1, 8'hF0, 8'h0F, 16'h1234, 3, "wrap store");
    expR(8'hFF); expR(8'h00); doneQ.push_back(16'h1234);
    runReq(1'b0, 1'b1, 8'hF0, 8'h0F, 16'h0000, 3, "wrap load");
    expR(8'h10); doneQ.push_back(16'h004A);
    runReq(1'b0, 1'b0, 8'h80, 8'h90, 16'h0000, 2, "ea wrap load");

    // start held high across a pair load; fields change while busy.
    expR(8'h20); expR(8'h21); doneQ.push_back(16'hBEEF);
    expR(8'h21); doneQ.push_back(16'h00BE);
    @(negedge CLK);
    start = 1'b1; is_store = 1'b0; is_pair = 1'b1; base = 8'h20; offset = 8'h00;
    doneCnt = 0;
    @(negedge CLK);
    chk("held start busy T+1", {31'd0, busy}, 32'd1);
    doneCnt += int'(done);
    is_pair = 1'b0; base = 8'h21;
    @(negedge CLK);
    chk("held start busy T+2", {31'd0, busy}, 32'd1);
    doneCnt += int'(done);
    @(negedge CLK);
    chk("held start busy T+3", {31'd0, busy}, 32'd1);
    chk("held start done T+3", {31'd0, done}, 32'd1);
    doneCnt += int'(done);
    @(negedge CLK);
    chk("held start idle T+4", {31'd0, busy}, 32'd0);
    doneCnt += int'(done);
    chk("held start one done", doneCnt, 1);
    @(negedge CLK);
    chk("held start reaccept T+5", {31'd0, busy}, 32'd1);
    start = 1'b0; base = 8'h00;
    @(negedge CLK);
    chk("second req done T+6", {31'd0, done}, 32'd1);
    @(negedge CLK);

    // Reset during ACC1 of a pair store.
    expW(8'h40, 8'h66);
    @(negedge CLK);
    start = 1'b1; is_store = 1'b1; is_pair = 1'b1; base = 8'h40; offset = 8'h00;
    wdata = 16'h5566;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    @(posedge CLK);
    #1 reset = 1'b1;
    #1 chk("abort write gated", {31'd0, mem_write}, 32'd0);
    @(posedge CLK);
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort rdata", {16'd0, rdata}, 32'd0);
    chk("abort mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("abort strobes", {29'd0, mem_read, mem_write, |mem_wdata}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort mem 0x40", {24'd0, mem[8'h40]}, 32'h66);
    chk("abort mem 0x41", {24'd0, mem[8'h41]}, 32'h1B);

    // rdata holds across a store.
    expW(8'h50, 8'h42); doneQ.push_back(16'h0000);
    runReq(1'b1, 1'b0, 8'h50, 8'h00, 16'h0042, 2, "hold setup store");
    expR(8'h50); doneQ.push_back(16'h0042);
    runReq(1'b0, 1'b0, 8'h50, 8'h00, 16'h0000, 2, "hold load");
    expW(8'h60, 8'h99); expW(8'h61, 8'h99); doneQ.push_back(16'h0042);
    runReq(1'b1, 1'b1, 8'h60, 8'h00, 16'h9999, 3, "hold store");
    chk("rdata hold", {16'd0, rdata}, 32'h0042);

    // Reset and start together: request dropped.
    @(negedge CLK);
    start = 1'b1; reset = 1'b1; is_store = 1'b1; is_pair = 1'b0; base = 8'h70;
    @(negedge CLK);
    start = 1'b0; reset = 1'b0;
    chk("reset+start busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge CLK);
    chk("reset+start still idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10 && (accQ.size() != 0 || doneQ.size() != 0); i++) @(negedge CLK);
    chk("access queue drained", accQ.size(), 0);
    chk("done queue drained", doneQ.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
